// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the async SRAM controller
package sram_pkg;
  localparam int SRAM_ADDR_W       = 18;
  localparam int SRAM_DATA_W       = 16;
  localparam int SRAM_WR_PULSE_DEF = 1;
  localparam int SRAM_RD_WAIT_DEF  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_ACCESS,
    ST_RD_END
  } state_t;
endpackage

// File: rtl/sram_bus_drv.sv
// rtl/sram_bus_drv.sv - tristate buffer isolating the bidirectional SRAM data pins
module sram_bus_drv
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              drive_en,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] sram_data
);
  assign sram_data = drive_en ? dout : {DATA_W{1'bz}};
  assign din       = sram_data;
endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port async SRAM controller with valid/ready request side
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int WR_PULSE = SRAM_WR_PULSE_DEF,
  parameter int RD_WAIT  = SRAM_RD_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we
);
  if (WR_PULSE < 1 || WR_PULSE > 15) begin : g_bad_wr_pulse
    $error("sram_ctrl: WR_PULSE must be in 1..15");
  end
  if (RD_WAIT < 0 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("sram_ctrl: RD_WAIT must be in 0..15");
  end

  localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);
  localparam logic [3:0] RD_LAST = 4'(RD_WAIT);

  state_t            state;
  logic [3:0]        cnt;
  logic              drive_en;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] din;

  assign req_ready = (state == ST_IDLE) & ~rst;
  assign busy      = (state != ST_IDLE);

  sram_bus_drv #(.DATA_W(DATA_W)) u_bus_drv (
    .drive_en (drive_en),
    .dout     (wdata_q),
    .din      (din),
    .sram_data(sram_data)
  );

  // Every pin is updated on the edge that enters the state it belongs to,
  // so pins reflect the state register with no combinational path from req_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      drive_en  <= 1'b0;
      wdata_q   <= '0;
      sram_addr <= '0;
      sram_cs   <= 1'b1;
      sram_oe   <= 1'b1;
      sram_we   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            sram_addr <= req_addr;
            sram_cs   <= 1'b0;
            cnt       <= '0;
            if (req_we) begin
              wdata_q  <= req_wdata;
              drive_en <= 1'b1;
              state    <= ST_WR_SETUP;
            end else begin
              sram_oe <= 1'b0;
              state   <= ST_RD_ACCESS;
            end
          end
        end
        ST_WR_SETUP: begin
          sram_we <= 1'b0;
          cnt     <= '0;
          state   <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt == WR_LAST) begin
            sram_we <= 1'b1;
            state   <= ST_WR_HOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_WR_HOLD: begin
          drive_en <= 1'b0;
          sram_cs  <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_RD_ACCESS: begin
          if (cnt == RD_LAST) begin
            rsp_rdata <= din;
            rsp_valid <= 1'b1;
            sram_oe   <= 1'b1;
            state     <= ST_RD_END;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        // cs stays low here so the bus turns around before it is released
        ST_RD_END: begin
          sram_cs <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl over three timing configurations
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [17:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;
  int          sel       = 0;

  logic [2:0]  rdy_v, rspv_v, busy_v, cs_v, oe_v, we_v, drv_v;
  logic [17:0] saddr_v    [3];
  logic [15:0] rdata_v    [3];
  logic [15:0] bus_v      [3];
  int          we_width_v [3];

  // instance 0: WR_PULSE=1 RD_WAIT=1; 1: WR_PULSE=2 RD_WAIT=0; 2: WR_PULSE=2 RD_WAIT=3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire [15:0]  data;
    logic [15:0] mem [0:262143];
    int          we_run   = 0;
    int          we_width = 0;

    assign data = (!cs_v[g] && !oe_v[g] && we_v[g]) ? mem[saddr_v[g]] : 16'bz;
    assign bus_v[g]      = data;
    assign we_width_v[g] = we_width;
    assign drv_v[g]      = u_dut.drive_en;

    sram_ctrl #(
      .ADDR_W  (18),
      .DATA_W  (16),
      .WR_PULSE((g == 0) ? 1 : 2),
      .RD_WAIT ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid && (sel == g)),
      .req_ready(rdy_v[g]),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rspv_v[g]),
      .rsp_rdata(rdata_v[g]),
      .busy     (busy_v[g]),
      .sram_addr(saddr_v[g]),
      .sram_data(data),
      .sram_cs  (cs_v[g]),
      .sram_oe  (oe_v[g]),
      .sram_we  (we_v[g])
    );

    always @(posedge clk) begin
      if (!cs_v[g] && !we_v[g]) mem[saddr_v[g]] <= data;
      if (!we_v[g]) we_run <= we_run + 1;
      else if (we_run != 0) begin
        we_width <= we_run;
        we_run   <= 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int bus_err = 0;
  int stab_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [2:0] oe_prev = 3'b111, drv_prev = 3'b000, rspv_prev = 3'b000;
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        if (drv_v[g] && !oe_v[g]) bus_err++;
        if (drv_v[g] && !drv_prev[g] && !oe_prev[g]) bus_err++;
        if (rspv_v[g] && rspv_prev[g]) bus_err++;
      end
    end
    oe_prev   = oe_v;
    drv_prev  = drv_v;
    rspv_prev = rspv_v;
  end

  task automatic do_op(input int s, input logic we, input logic [17:0] a, input logic [15:0] d,
                       output int n_busy, output int n_rsp, output logic [15:0] rd);
    n_busy = -1;
    n_rsp  = 0;
    rd     = '0;
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rspv_v[s] && n_rsp == 0) begin
        n_rsp = k;
        rd    = rdata_v[s];
      end
      if (rdy_v[s]) begin
        n_busy = k - 1;
        break;
      end
      if (saddr_v[s] !== a || (drv_v[s] && bus_v[s] !== d)) stab_err++;
    end
  endtask

  typedef struct {
    int          s;
    logic        we;
    logic [17:0] a;
    logic [15:0] d;
    int          exp_busy;
    int          exp_rsp;
    logic [15:0] exp_rd;
    int          exp_we;
  } vec_t;

  initial begin
    vec_t        v [10];
    int          nb, nr, n;
    logic [15:0] rd;

    v[0] = '{0, 1'b1, 18'h00012, 16'hA5C3, 3, 0, 16'h0000, 1};
    v[1] = '{0, 1'b0, 18'h00012, 16'h0000, 3, 3, 16'hA5C3, 0};
    v[2] = '{1, 1'b1, 18'h00100, 16'h1234, 4, 0, 16'h0000, 2};
    v[3] = '{1, 1'b0, 18'h00100, 16'h0000, 2, 2, 16'h1234, 0};
    v[4] = '{2, 1'b1, 18'h2AAAA, 16'h5A5A, 4, 0, 16'h0000, 2};
    v[5] = '{2, 1'b0, 18'h2AAAA, 16'h0000, 5, 5, 16'h5A5A, 0};
    v[6] = '{2, 1'b1, 18'h00000, 16'h0001, 4, 0, 16'h0000, 2};
    v[7] = '{2, 1'b0, 18'h00000, 16'h0000, 5, 5, 16'h0001, 0};
    v[8] = '{1, 1'b1, 18'h3FFFE, 16'h8001, 4, 0, 16'h0000, 2};
    v[9] = '{1, 1'b0, 18'h3FFFE, 16'h0000, 2, 2, 16'h8001, 0};

    // reset held with a pending request
    rst = 1'b1; sel = 0; req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h1; req_wdata = 16'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d_ready", i), {29'd0, rdy_v}, 32'd0);
      check($sformatf("rst%0d_cs_oe_we", i), {23'd0, cs_v, oe_v, we_v}, 32'h1FF);
      check($sformatf("rst%0d_drive_busy_rsp", i), {23'd0, drv_v, busy_v, rspv_v}, 32'd0);
    end
    check("rst_addr", {14'd0, saddr_v[0]}, 32'd0);
    check("rst_rdata", {16'd0, rdata_v[0]}, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {29'd0, rdy_v}, 32'h7);
    check("rst_release_busy", {29'd0, busy_v}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(v[i].s, v[i].we, v[i].a, v[i].d, nb, nr, rd);
      check($sformatf("v%0d_busy_cycles", i), nb, v[i].exp_busy);
      if (v[i].we) begin
        check($sformatf("v%0d_we_width", i), we_width_v[v[i].s], v[i].exp_we);
      end else begin
        check($sformatf("v%0d_rsp_latency", i), nr, v[i].exp_rsp);
        check($sformatf("v%0d_rdata", i), {16'd0, rd}, {16'd0, v[i].exp_rd});
      end
    end

    // back-to-back write then read held valid on instance 0
    @(negedge clk);
    sel = 0; req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h3FFFF; req_wdata = 16'hFFFF;
    @(posedge clk);
    #1 req_we = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy_v[0]) begin n = k; break; end
    end
    check("b2b_gap", n, 4);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rspv_v[0]) begin n = k; rd = rdata_v[0]; break; end
    end
    check("b2b_rsp_latency", n, 3);
    check("b2b_rdata", {16'd0, rd}, 32'h0000FFFF);

    // reset during write pulse, then during read access, on instance 2
    do_op(2, 1'b1, 18'h00155, 16'hBEEF, nb, nr, rd);
    @(negedge clk);
    sel = 2; req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00156; req_wdata = 16'hDEAD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_wr_we_low", {31'd0, we_v[2]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wr_pins", {28'd0, we_v[2], oe_v[2], cs_v[2], drv_v[2]}, 32'hE);
    check("abort_wr_busy", {31'd0, busy_v[2]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    sel = 2; req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00155;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_rd_oe_low", {31'd0, oe_v[2]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rd_pins", {28'd0, we_v[2], oe_v[2], cs_v[2], drv_v[2]}, 32'hE);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rspv_v[2]) n++;
    end
    check("abort_rd_no_rsp", n, 0);
    do_op(2, 1'b0, 18'h00155, 16'h0000, nb, nr, rd);
    check("post_abort_latency", nr, 5);
    check("post_abort_rdata", {16'd0, rd}, 32'h0000BEEF);

    check("bus_safety", bus_err, 0);
    check("addr_data_stable", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
